// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers fetched words with their PC, decodes register and immediate fields on write.
// Latency: one cycle from push to out_valid (zero when IFQ_BYPASS_EN is defined and the queue is empty).
// Backpressure: in_ready is registered and low while full; the head is held until out_ready; flush empties the queue.
//
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a word arriving at an empty queue is
// presented combinationally on the outputs. If it is consumed in that cycle, it is never stored.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     fetch-side handshake; in_instr and in_pc carry the word and its PC
//   flush                 discard every entry (taken branch or jump); wins over a push or pop in the same cycle
//   out_valid/out_ready   datapath-side handshake for the head entry
//   opcode .. out_pc      head entry fields, driven to zero when nothing is valid
//   count                 number of stored entries
module instr_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter int         PC_W     = 32,
    parameter logic [5:0] OP_STORE = 6'b100001,
    parameter logic [5:0] OP_SWAP  = 6'b111100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [PC_W-1:0]           in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                opcode,
    output logic [4:0]                read_sel_1,
    output logic [4:0]                read_sel_2,
    output logic [4:0]                write_address,
    output logic [15:0]               immediate,
    output logic [25:0]               jump_imm,
    output logic [PC_W-1:0]           out_pc,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [5:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      wa;
        logic [15:0]     imm;
        logic [25:0]     jimm;
        logic [PC_W-1:0] pc;
    } entry_t;

    // Read-select routing depends on the opcode. It is resolved here, before storage,
    // so that the output path is only a storage read.
    function automatic entry_t decode(input logic [31:0] w, input logic [PC_W-1:0] pc);
        entry_t e;
        e.op   = w[31:26];
        e.wa   = w[25:21];
        e.imm  = w[15:0];
        e.jimm = w[25:0];
        e.pc   = pc;
        if (w[31:26] == OP_STORE) begin
            e.rs1 = w[25:21];
            e.rs2 = w[20:16];
        end else if (w[31:26] == OP_SWAP) begin
            e.rs1 = w[20:16];
            e.rs2 = w[25:21];
        end else begin
            e.rs1 = w[20:16];
            e.rs2 = w[15:11];
        end
        return e;
    endfunction

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;

    entry_t          in_dec;
    entry_t          head;
    logic            empty;
    logic            byp;
    logic            push_st;
    logic            pop_st;

    assign in_dec = decode(in_instr, in_pc);
    assign empty  = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    assign byp = empty && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that is taken in the same cycle never occupies a slot.
    assign push_st = in_valid && in_ready_q && !flush && !(byp && out_ready);
    assign pop_st  = !empty && out_ready && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_st) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_st)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_st) - CW'(pop_st);
        end
        // Registered so that the fetch side sees no combinational path from out_ready.
        in_ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage has no reset. Its contents are never visible while the queue is empty.
    always_ff @(posedge clk) begin
        if (!reset && push_st) mem_q[wr_ptr_q] <= in_dec;
    end

    always_comb begin
        head = '0;
        if (!empty)   head = mem_q[rd_ptr_q];
        else if (byp) head = in_dec;
    end

    assign out_valid     = !empty || byp;
    assign in_ready      = in_ready_q;
    assign count         = count_q;
    assign opcode        = head.op;
    assign read_sel_1    = head.rs1;
    assign read_sel_2    = head.rs2;
    assign write_address = head.wa;
    assign immediate     = head.imm;
    assign jump_imm      = head.jimm;
    assign out_pc        = head.pc;

endmodule
